id_regfile_pipe: RTL and testbench
==================================

Name: id_regfile_pipe

Overview:
- Parametrised, clocked successor to the ID-stage register file.
- Decodes rs/rt/rd from the instruction, reads two operands and extends the 16-bit immediate with a selectable mode.
- Registers all results into the ID/EX boundary with stall/flush control.
- Synchronous write port from WB with internal write-to-read bypass, so the WB→ID same-cycle hazard is resolved in the block; r0 reads as zero.

Parameters:
- DATA_W, 32: register and data width; legal 18..64.
- ADDR_W, 5: register address width; legal 1..5; depth = 2**ADDR_W.
- ZERO_REG, 1: 1 = register 0 hardwired to zero; 0 = register 0 is writable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- instr  in  32  MIPS instruction in ID.
- id_valid  in  1  instr is a valid instruction.
- stall  in  1  hold the ID/EX output registers.
- flush  in  1  insert a bubble into ID/EX.
- ext_mode  in  2  immediate mode: 00 zero-extend, 01 sign-extend, 10 upper (imm<<16), 11 branch (sign-extend then <<2).
- reg_write  in  1  WB write enable.
- write_reg  in  ADDR_W  WB destination.
- write_data  in  DATA_W  WB data.
- read_data1  out  DATA_W  registered rs operand.
- read_data2  out  DATA_W  registered rt operand.
- ext_imm  out  DATA_W  registered extended immediate.
- rs_out, rt_out, rd_out  out  ADDR_W each  registered register fields.
- ex_valid  out  1  registered valid to EX.

Behaviour:
- Field decode:
  - rs = instr[21 +: ADDR_W]
  - rt = instr[16 +: ADDR_W]
  - rd = instr[11 +: ADDR_W]
  - imm = instr[15:0]
- Reset (rst_n low, asynchronous):
  - All array entries clear to 0.
  - Every output clears to 0, including ex_valid = 0.
  - Reset asserted mid-stall or mid-write drops the write and all held state.
- Write:
  - On the rising edge, if reg_write=1, array[write_reg] <= write_data.
  - If ZERO_REG=1 and write_reg=0, the write is ignored.
- Read, combinational, internal:
  - opX = 0 when ZERO_REG=1 and the address is 0.
  - Else opX = write_data when reg_write=1 and write_reg equals the address (bypass).
  - Else opX = array[address].
- Extension, combinational, result DATA_W bits:
  - 00: {0, imm}
  - 01: imm[15] replicated, then imm
  - 10: imm in bits [31:16], low 16 bits zero; for DATA_W>32 the upper bits are zero-filled, and for DATA_W<32 the result is truncated.
  - 11: sign-extended imm shifted left 2, then truncated to DATA_W.
- Output register update on each rising edge, priority flush > stall > load:
  - flush=1: ex_valid <= 0; data and field outputs <= 0. Flush overrides a simultaneous stall.
  - stall=1 (no flush): all outputs hold. A WB write still updates the array. The held read_data does not refresh, so the hazard unit owns re-forwarding.
  - Otherwise: load opA, opB, ext, the fields, and ex_valid <= id_valid.
- Latency: one cycle from instr to outputs.
- A write in cycle N is visible to a read in the same cycle N via the bypass, and therefore appears at the outputs after edge N.
- Simultaneous write to r0 with a read of r0 (ZERO_REG=1): the output is 0.
- No X propagation: the array is always initialised by reset.

Test Plan:
1. Reset, then write r5=0xDEADBEEF; the next cycle issue instr with rs=5, rt=0 → after one edge read_data1=0xDEADBEEF, read_data2=0, ex_valid=1.
2. Same-cycle bypass: reg_write=1, write_reg=8, write_data=0x12345678 while instr rs=8 → at the next edge read_data1=0x12345678. Also write_reg=0 with data 0xFFFFFFFF and a read of r0 → 0 (ZERO_REG=1).
3. Extension with imm=0x8004:
   - mode 00 → 0x00008004
   - mode 01 → 0xFFFF8004
   - mode 10 → 0x80040000
   - mode 11 → 0xFFFE0010
4. Stall for 3 cycles while changing instr and writing r3=0x55 → outputs frozen. After release the next load shows r3=0x55 if rs=3.
5. Assert flush and stall together with id_valid=1 → ex_valid=0 and all outputs 0 at the next edge.
6. Drop rst_n asynchronously mid-clock after several writes → outputs 0 immediately without a clock edge. After release, reads of previously written registers return 0.

Source files
------------

// File: rtl/id_regfile_pipe_if.sv
// ---------------------------------------------------------------------------
// id_regfile_pipe_if
// Signal bundle between the ID stage / WB stage and the ID register file
// pipeline block.
//   master : instruction source and WB writer (drives instr, id_valid, stall,
//            flush, ext_mode, reg_write, write_reg, write_data; observes
//            the registered ID/EX outputs).
//   slave  : the register file block (id_regfile_pipe).
// Parameters DATA_W / ADDR_W must match the ones given to the block.
// ---------------------------------------------------------------------------
interface id_regfile_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [31:0]       instr;
    logic              id_valid;
    logic              stall;
    logic              flush;
    logic [1:0]        ext_mode;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;

    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] ext_imm;
    logic [ADDR_W-1:0] rs_out;
    logic [ADDR_W-1:0] rt_out;
    logic [ADDR_W-1:0] rd_out;
    logic              ex_valid;

    modport master (
        output instr, id_valid, stall, flush, ext_mode,
               reg_write, write_reg, write_data,
        input  read_data1, read_data2, ext_imm, rs_out, rt_out, rd_out, ex_valid
    );

    modport slave (
        input  instr, id_valid, stall, flush, ext_mode,
               reg_write, write_reg, write_data,
        output read_data1, read_data2, ext_imm, rs_out, rt_out, rd_out, ex_valid
    );
endinterface

// File: rtl/id_regfile_pipe.sv
// ---------------------------------------------------------------------------
// id_regfile_pipe
// ID-stage register file with registered ID/EX boundary.
//   - Decodes rs/rt/rd/imm from the instruction, reads two operands, extends
//     the immediate (zero / sign / upper / branch), and registers everything
//     into ID/EX with flush > stall > load priority.
//   - WB write port with same-cycle write-to-read bypass; optional hardwired
//     zero register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears array and all outputs)
//   bus   : id_regfile_pipe_if.slave (instruction, control, WB write port,
//           registered ID/EX outputs)
// ---------------------------------------------------------------------------
module id_regfile_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    id_regfile_pipe_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];

    logic [ADDR_W-1:0] rs_s;
    logic [ADDR_W-1:0] rt_s;
    logic [ADDR_W-1:0] rd_s;
    logic [15:0]       imm_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;
    logic [DATA_W-1:0] sext_s;
    logic [DATA_W+15:0] upper_wide_s;
    logic [DATA_W-1:0] ext_s;
    // Opcode/funct bits are not needed here; fold the whole word so it counts as used.
    logic              unused_instr_s;

    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] ext_q, ext_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [ADDR_W-1:0] rt_q, rt_d;
    logic [ADDR_W-1:0] rdf_q, rdf_d;
    logic              vld_q, vld_d;

    assign rs_s           = bus.instr[21 +: ADDR_W];
    assign rt_s           = bus.instr[16 +: ADDR_W];
    assign rd_s           = bus.instr[11 +: ADDR_W];
    assign imm_s          = bus.instr[15:0];
    assign unused_instr_s = ^bus.instr;

    // Writes to r0 are dropped when it is hardwired, so the array never holds a nonzero r0.
    assign wr_en_s = bus.reg_write &&
                     !((ZERO_REG != 0) && (bus.write_reg == {ADDR_W{1'b0}}));

    // Operand read: hardwired zero first, then WB bypass, then the array.
    function automatic logic [DATA_W-1:0] read_op(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] arr_val
    );
        if ((ZERO_REG != 0) && (addr == {ADDR_W{1'b0}})) begin
            return {DATA_W{1'b0}};
        end else if (bus.reg_write && (bus.write_reg == addr)) begin
            return bus.write_data;
        end else begin
            return arr_val;
        end
    endfunction

    // Combinational operand fetch for rs and rt.
    always_comb begin
        op_a_s = read_op(rs_s, regs_q[rs_s]);
        op_b_s = read_op(rt_s, regs_q[rt_s]);
    end

    // Immediate extension; upper mode is built wide then truncated so it works on both sides of 32 bits.
    always_comb begin
        sext_s       = {{(DATA_W-16){imm_s[15]}}, imm_s};
        upper_wide_s = {{DATA_W{1'b0}}, imm_s} << 5'd16;
        case (bus.ext_mode)
            2'b00:   ext_s = {{(DATA_W-16){1'b0}}, imm_s};
            2'b01:   ext_s = sext_s;
            2'b10:   ext_s = upper_wide_s[DATA_W-1:0];
            2'b11:   ext_s = sext_s << 2'd2;
            default: ext_s = {DATA_W{1'b0}};
        endcase
    end

    // Register array: async clear, WB write on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_q[bus.write_reg] <= bus.write_data;
        end
    end

    // ID/EX next state: flush beats stall, stall holds, otherwise load.
    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        ext_d = ext_q;
        rs_d  = rs_q;
        rt_d  = rt_q;
        rdf_d = rdf_q;
        vld_d = vld_q;
        if (bus.flush) begin
            rd1_d = {DATA_W{1'b0}};
            rd2_d = {DATA_W{1'b0}};
            ext_d = {DATA_W{1'b0}};
            rs_d  = {ADDR_W{1'b0}};
            rt_d  = {ADDR_W{1'b0}};
            rdf_d = {ADDR_W{1'b0}};
            vld_d = 1'b0;
        end else if (bus.stall) begin
            vld_d = vld_q;
        end else begin
            rd1_d = op_a_s;
            rd2_d = op_b_s;
            ext_d = ext_s;
            rs_d  = rs_s;
            rt_d  = rt_s;
            rdf_d = rd_s;
            vld_d = bus.id_valid;
        end
    end

    // ID/EX output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q <= {DATA_W{1'b0}};
            rd2_q <= {DATA_W{1'b0}};
            ext_q <= {DATA_W{1'b0}};
            rs_q  <= {ADDR_W{1'b0}};
            rt_q  <= {ADDR_W{1'b0}};
            rdf_q <= {ADDR_W{1'b0}};
            vld_q <= 1'b0;
        end else begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
            ext_q <= ext_d;
            rs_q  <= rs_d;
            rt_q  <= rt_d;
            rdf_q <= rdf_d;
            vld_q <= vld_d;
        end
    end

    assign bus.read_data1 = rd1_q;
    assign bus.read_data2 = rd2_q;
    assign bus.ext_imm    = ext_q;
    assign bus.rs_out     = rs_q;
    assign bus.rt_out     = rt_q;
    assign bus.rd_out     = rdf_q;
    assign bus.ex_valid   = vld_q;

endmodule

// File: tb/tb_id_regfile_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_regfile_pipe
// Directed bench for id_regfile_pipe (DATA_W=32, ADDR_W=5, ZERO_REG=1).
// A reference model (write-then-read register array plus arithmetic
// immediate extension) predicts the ID/EX outputs; a compare process checks
// them on every falling clock edge, and directed steps pin literal values.
// ---------------------------------------------------------------------------
module tb_id_regfile_pipe;
    logic clk;
    logic rst_n;

    int checks;
    int errors;

    id_regfile_pipe_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    id_regfile_pipe #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] e_rd1, e_rd2, e_ext;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic        e_vld;

    // Value a register read sees this cycle: the array as it will be after this edge's WB write.
    function automatic logic [31:0] visible(input logic [4:0] a);
        logic [31:0] arr [32];
        arr = m_regs;
        if (bus.reg_write && bus.write_reg != 5'd0) arr[bus.write_reg] = bus.write_data;
        return arr[a];
    endfunction

    function automatic logic [31:0] ext_of(input logic [1:0] mode, input logic [15:0] imm);
        logic signed [31:0] s;
        s = 32'(signed'(imm));
        case (mode)
            2'd0:    return {16'd0, imm};
            2'd1:    return s;
            2'd2:    return 32'(imm) * 32'd65536;
            2'd3:    return 32'(s * 32'sd4);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            e_rd1 <= 32'd0; e_rd2 <= 32'd0; e_ext <= 32'd0;
            e_rs <= 5'd0; e_rt <= 5'd0; e_rd <= 5'd0; e_vld <= 1'b0;
        end else begin
            if (bus.reg_write && bus.write_reg != 5'd0) m_regs[bus.write_reg] <= bus.write_data;
            if (bus.flush) begin
                e_rd1 <= 32'd0; e_rd2 <= 32'd0; e_ext <= 32'd0;
                e_rs <= 5'd0; e_rt <= 5'd0; e_rd <= 5'd0; e_vld <= 1'b0;
            end else if (!bus.stall) begin
                e_rd1 <= visible(bus.instr[25:21]);
                e_rd2 <= visible(bus.instr[20:16]);
                e_ext <= ext_of(bus.ext_mode, bus.instr[15:0]);
                e_rs  <= bus.instr[25:21];
                e_rt  <= bus.instr[20:16];
                e_rd  <= bus.instr[15:11];
                e_vld <= bus.id_valid;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("m_rd1", bus.read_data1, e_rd1);
        chk("m_rd2", bus.read_data2, e_rd2);
        chk("m_ext", bus.ext_imm, e_ext);
        chk("m_rs",  32'(bus.rs_out), 32'(e_rs));
        chk("m_rt",  32'(bus.rt_out), 32'(e_rt));
        chk("m_rd",  32'(bus.rd_out), 32'(e_rd));
        chk("m_vld", 32'(bus.ex_valid), 32'(e_vld));
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic vld, input logic [1:0] mode,
                         input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                         input logic st, input logic fl);
        bus.instr = ins; bus.id_valid = vld; bus.ext_mode = mode;
        bus.reg_write = rw; bus.write_reg = wr; bus.write_data = wd;
        bus.stall = st; bus.flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ext_tab [4];

    initial begin
        checks = 0;
        errors = 0;
        ext_tab[0] = 32'h0000_8004;
        ext_tab[1] = 32'hFFFF_8004;
        ext_tab[2] = 32'h8004_0000;
        ext_tab[3] = 32'hFFFE_0010;
        rst_n = 1'b0;
        drive(32'd0, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) step();
        chk("rst_rd1", bus.read_data1, 32'd0);
        chk("rst_vld", 32'(bus.ex_valid), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: write r5 then read it
        drive(32'd0, 1'b0, 2'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        step();
        drive(mk(5'd5, 5'd0, 16'h0000), 1'b1, 2'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("t1_rd1", bus.read_data1, 32'hDEADBEEF);
        chk("t1_rd2", bus.read_data2, 32'd0);
        chk("t1_vld", 32'(bus.ex_valid), 32'd1);

        // 2: same-cycle bypass, and r0 write ignored
        drive(mk(5'd8, 5'd5, 16'h0000), 1'b1, 2'd0, 1'b1, 5'd8, 32'h12345678, 1'b0, 1'b0);
        step();
        chk("t2_byp", bus.read_data1, 32'h12345678);
        chk("t2_rt5", bus.read_data2, 32'hDEADBEEF);
        drive(mk(5'd0, 5'd0, 16'h0000), 1'b1, 2'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        step();
        chk("t2_r0a", bus.read_data1, 32'd0);
        chk("t2_r0b", bus.read_data2, 32'd0);

        // 3: extension modes with imm=0x8004
        for (int m = 0; m < 4; m++) begin
            drive(mk(5'd1, 5'd2, 16'h8004), 1'b1, 2'(m), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            step();
            chk("t3_ext", bus.ext_imm, ext_tab[m]);
        end
        chk("t3_rdf", 32'(bus.rd_out), 32'd16);
        chk("t3_rs", 32'(bus.rs_out), 32'd1);

        // 4: stall three cycles while instr changes and r3 is written
        for (int c = 0; c < 3; c++) begin
            drive(mk(5'd3, 5'd3, 16'(c)), 1'b0, 2'd0, 1'b1, 5'd3, 32'h55, 1'b1, 1'b0);
            step();
            chk("t4_hold_ext", bus.ext_imm, 32'hFFFE_0010);
            chk("t4_hold_rs", 32'(bus.rs_out), 32'd1);
            chk("t4_hold_vld", 32'(bus.ex_valid), 32'd1);
        end
        drive(mk(5'd3, 5'd0, 16'h0000), 1'b1, 2'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("t4_r3", bus.read_data1, 32'h55);

        // 5: flush together with stall
        drive(mk(5'd3, 5'd5, 16'hFFFF), 1'b1, 2'd1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        step();
        chk("t5_vld", 32'(bus.ex_valid), 32'd0);
        chk("t5_rd1", bus.read_data1, 32'd0);
        chk("t5_ext", bus.ext_imm, 32'd0);
        chk("t5_rt", 32'(bus.rt_out), 32'd0);

        // 6: asynchronous reset mid-cycle after writes
        drive(32'd0, 1'b0, 2'd0, 1'b1, 5'd9, 32'h0000A5A5, 1'b0, 1'b0);
        step();
        drive(mk(5'd9, 5'd5, 16'h1234), 1'b1, 2'd0, 1'b1, 5'd10, 32'h77, 1'b0, 1'b0);
        step();
        chk("t6_pre", bus.read_data1, 32'h0000A5A5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rd1", bus.read_data1, 32'd0);
        chk("t6_async_vld", 32'(bus.ex_valid), 32'd0);
        chk("t6_async_ext", bus.ext_imm, 32'd0);
        step();
        rst_n = 1'b1;
        drive(mk(5'd9, 5'd5, 16'h0000), 1'b1, 2'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("t6_r9", bus.read_data1, 32'd0);
        chk("t6_r5", bus.read_data2, 32'd0);
        chk("t6_vld", 32'(bus.ex_valid), 32'd1);
        drive(mk(5'd10, 5'd8, 16'h0000), 1'b1, 2'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("t6_r10", bus.read_data1, 32'd0);
        chk("t6_r8", bus.read_data2, 32'd0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
